// File: rtl/prog_loader.sv
// Byte-stream program loader: [len32 BE][payload][csum if LOADER_CHECKSUM_EN] -> instruction memory byte writes.
// Latency 1 (write strobe the cycle after rx_valid); no backpressure, every rx_valid byte is consumed.
`ifndef INS_START_ADDRESS
`define INS_START_ADDRESS 32'h0000_0000
`endif

module prog_loader #(
    parameter logic [31:0] BASE_ADDR      = `INS_START_ADDRESS,
    parameter int unsigned MEM_BYTES      = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset_n,
    input  logic        load_start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        PC_to_mem_enable,
    output logic [7:0]  PC_to_mem_data,
    output logic [31:0] PC_to_mem_address,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERROR} state_t;
    localparam state_t AFTER_PAYLOAD = CSUM;
`else
    typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERROR} state_t;
    localparam state_t AFTER_PAYLOAD = DONE;
`endif

    state_t         state, state_nxt;
    logic [31:0]    len;
    logic [31:0]    len_nxt;
    logic [31:0]    byte_cnt;
    logic [TW-1:0]  timer;
    logic           timeout;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]     sum;
`endif

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = {len[23:0], rx_data};
        timeout   = (timer == TW'(TIMEOUT_CYCLES - 1));
        case (state)
            IDLE, DONE, ERROR: begin
                if (load_start) state_nxt = LEN;
            end
            LEN: begin
                if (rx_valid) begin
                    if (byte_cnt[1:0] == 2'd3) begin
                        if (len_nxt == 32'd0)                 state_nxt = AFTER_PAYLOAD;
                        else if (len_nxt > 32'(MEM_BYTES))    state_nxt = ERROR;
                        else                                  state_nxt = DATA;
                    end
                end else if (timeout) begin
                    state_nxt = ERROR;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    if (byte_cnt == len - 32'd1) state_nxt = AFTER_PAYLOAD;
                end else if (timeout) begin
                    state_nxt = ERROR;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (rx_valid)     state_nxt = (rx_data == sum) ? DONE : ERROR;
                else if (timeout) state_nxt = ERROR;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: length shifter, byte counter, idle timer and the memory write port.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            len               <= 32'd0;
            byte_cnt          <= 32'd0;
            timer             <= '0;
            PC_to_mem_enable  <= 1'b0;
            PC_to_mem_data    <= 8'd0;
            PC_to_mem_address <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            sum               <= 8'd0;
`endif
        end else begin
            PC_to_mem_enable <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (load_start) begin
                        len      <= 32'd0;
                        byte_cnt <= 32'd0;
                        timer    <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum      <= 8'd0;
`endif
                    end
                end
                LEN: begin
                    if (rx_valid) begin
                        len      <= len_nxt;
                        timer    <= '0;
                        // Counter is reused as payload index once the header is complete.
                        byte_cnt <= (byte_cnt[1:0] == 2'd3) ? 32'd0 : byte_cnt + 32'd1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        PC_to_mem_enable  <= 1'b1;
                        PC_to_mem_data    <= rx_data;
                        PC_to_mem_address <= BASE_ADDR + byte_cnt;
                        byte_cnt          <= byte_cnt + 32'd1;
                        timer             <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum               <= sum + rx_data;
`endif
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (rx_valid) timer <= '0;
                    else          timer <= timer + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign load_busy = (state == LEN) || (state == DATA) || (state == CSUM);
`else
    assign load_busy = (state == LEN) || (state == DATA);
`endif
    assign load_done  = (state == DONE);
    assign load_error = (state == ERROR);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          TO   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [31:0] wr_addr;
    logic        busy, done, err;

    int checks = 0;
    int failures = 0;

    prog_loader #(.BASE_ADDR(BASE), .MEM_BYTES(1000), .TIMEOUT_CYCLES(TO)) dut (
        .SYS_clk(clk),
        .SYS_reset_n(rst_n),
        .load_start(load_start),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .PC_to_mem_enable(wr_en),
        .PC_to_mem_data(wr_data),
        .PC_to_mem_address(wr_addr),
        .load_busy(busy),
        .load_done(done),
        .load_error(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status as {busy, done, error}
    task automatic chk_st(input string tag, input logic [2:0] exp);
        checks++;
        assert ({busy, done, err} === exp) else begin
            failures++;
            $error("FAIL %s status observed=%b expected=%b", tag, {busy, done, err}, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [7:0] d, input logic [31:0] a);
        checks++;
        assert ({wr_en, wr_data, wr_addr} === {en, d, a}) else begin
            failures++;
            $error("FAIL %s write observed=%b/%h/%h expected=%b/%h/%h", tag, wr_en, wr_data, wr_addr, en, d, a);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        logic [7:0] pay [4];
        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;

        // Reset state
        tick();
        chk_st("reset_status", 3'b000);
        chk_wr("reset_write", 1'b0, 8'h00, 32'h0);
        rst_n = 1'b1;
        tick();

        // Normal 4-byte load
        start();
        chk_st("start_busy", 3'b100);
        send(8'h00); send(8'h00); send(8'h00);
        chk_wr("len_no_strobe", 1'b0, 8'h00, 32'h0);
        send(8'h04);
        chk_st("len4_data", 3'b100);
        for (int i = 0; i < 4; i++) begin
            send(pay[i]);
            chk_wr("normal_strobe", 1'b1, pay[i], BASE + 32'(i));
            chk_st("normal_status", (i == 3) ? 3'b010 : 3'b100);
        end
        tick();
        chk_wr("normal_hold", 1'b0, 8'hEF, BASE + 32'd3);
        send(8'h55);
        chk_wr("done_ignores_rx", 1'b0, 8'hEF, BASE + 32'd3);
        chk_st("done_stays", 3'b010);

        // Zero length
        start();
        chk_st("zero_start_clears_done", 3'b100);
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        chk_wr("zero_no_strobe", 1'b0, 8'hEF, BASE + 32'd3);
`ifdef LOADER_CHECKSUM_EN
        chk_st("zero_csum_wait", 3'b100);
        send(8'h00);
`endif
        chk_st("zero_done", 3'b010);

        // Oversize length 1001
        start();
        send(8'h00); send(8'h00); send(8'h03); send(8'hE9);
        chk_st("oversize_error", 3'b001);
        send(8'h11);
        chk_wr("oversize_no_strobe", 1'b0, 8'hEF, BASE + 32'd3);
        chk_st("oversize_stays", 3'b001);

        // Length 1000 is legal; reset asynchronously mid-DATA
        start();
        chk_st("error_start_clears", 3'b100);
        send(8'h00); send(8'h00); send(8'h03); send(8'hE8);
        chk_st("maxlen_data", 3'b100);
        send(8'h5A);
        chk_wr("maxlen_strobe0", 1'b1, 8'h5A, BASE);
        send(8'hA5);
        chk_wr("maxlen_strobe1", 1'b1, 8'hA5, BASE + 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_wr("async_reset_write", 1'b0, 8'h00, 32'h0);
        chk_st("async_reset_status", 3'b000);
        send(8'h77);
        chk_wr("in_reset_no_strobe", 1'b0, 8'h00, 32'h0);
        rst_n = 1'b1;
        send(8'h77);
        chk_wr("idle_no_strobe", 1'b0, 8'h00, 32'h0);
        chk_st("idle_after_reset", 3'b000);

        // Timeout mid-header
        start();
        send(8'h00); send(8'h00);
        for (int i = 0; i < TO - 1; i++) tick();
        chk_st("timeout_not_yet", 3'b100);
        tick();
        chk_st("timeout_error", 3'b001);

        // Byte on the expiry cycle wins
        start();
        send(8'h00); send(8'h00);
        for (int i = 0; i < TO - 1; i++) tick();
        send(8'h00);
        chk_st("expiry_byte_wins", 3'b100);
        send(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        chk_st("expiry_then_done", 3'b010);

        // 3-byte payload 01 02 03 (checksum 06 good, 07 bad when built)
        for (int pass = 0; pass < 2; pass++) begin
            start();
            send(8'h00); send(8'h00); send(8'h00); send(8'h03);
            for (int i = 0; i < 3; i++) begin
                send(8'(i + 1));
                chk_wr("p3_strobe", 1'b1, 8'(i + 1), BASE + 32'(i));
            end
`ifdef LOADER_CHECKSUM_EN
            chk_st("p3_csum_wait", 3'b100);
            send((pass == 0) ? 8'h06 : 8'h07);
            chk_wr("p3_csum_no_strobe", 1'b0, 8'h03, BASE + 32'd2);
            chk_st("p3_csum_result", (pass == 0) ? 3'b010 : 3'b001);
`else
            chk_st("p3_done", 3'b010);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
